// File: rtl/agc_gain_responder.sv
// rtl/agc_gain_responder.sv - AGC datapath partner: peak detect, done/indicator, gain code owner
// Optional preamble timeout is built when macro AGC_TIMEOUT_EN is defined.
module agc_gain_responder #(
  parameter int DATA_W       = 8,
  parameter int GAIN_W       = 5,
  parameter int GAIN_INIT    = 16,
  parameter int HI_TH        = 96,
  parameter int LO_TH        = 48,
  parameter int MIN_SAMPLES  = 8,
  parameter int PREAMBLE_LEN = 200
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     sample_valid,
  input  logic                     detect_mode,
  input  logic                     adjust,
  input  logic                     up_dn,
  input  logic                     preamble_counter_mode,
  output logic                     indicator,
  output logic                     done,
  output logic [GAIN_W-1:0]        gain,
  output logic                     gain_update,
  output logic                     timeout
);

  localparam int MAG_W = DATA_W - 1;
  localparam int CNT_W = $clog2(MIN_SAMPLES + 1);
  localparam logic [MAG_W-1:0]  HI_L     = MAG_W'(HI_TH);
  localparam logic [MAG_W-1:0]  LO_L     = MAG_W'(LO_TH);
  localparam logic [MAG_W-1:0]  MAG_MAX  = {MAG_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_L    = CNT_W'(MIN_SAMPLES);
  localparam logic [GAIN_W-1:0] GAIN_MAX = {GAIN_W{1'b1}};
  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);

  logic              detect_d_q, adjust_d_q;
  logic [MAG_W-1:0]  peak_q, peak_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic              indicator_q, indicator_d;
  logic              done_q, done_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              gain_update_q, gain_update_d;
  logic              timeout_q, timeout_d;

  logic [DATA_W-1:0] neg_s;
  logic [MAG_W-1:0]  mag;
  logic              det_rise, adj_rise, inband, to_hit, done_set;

  // Most-negative sample has no positive twin; clamp it to the largest magnitude.
  assign neg_s = -sample;
  always_comb begin
    mag = sample[MAG_W-1:0];
    if (sample[DATA_W-1]) begin
      if (sample[MAG_W-1:0] == '0) mag = MAG_MAX;
      else                         mag = neg_s[MAG_W-1:0];
    end
  end

  assign det_rise = detect_mode & ~detect_d_q;
  assign adj_rise = adjust & ~adjust_d_q;

  always_comb begin
    peak_d      = peak_q;
    win_cnt_d   = win_cnt_q;
    indicator_d = indicator_q;
    if (detect_mode) begin
      if (det_rise) begin
        peak_d    = '0;
        win_cnt_d = '0;
      end
      if (sample_valid) begin
        if (mag > peak_d)      peak_d    = mag;
        if (win_cnt_d < MIN_L) win_cnt_d = win_cnt_d + 1'b1;
      end
      indicator_d = (peak_d > HI_L);
    end
  end

  assign inband = detect_mode && (win_cnt_d >= MIN_L) && (peak_d >= LO_L) && (peak_d <= HI_L);

`ifdef AGC_TIMEOUT_EN
  localparam int PC_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PC_W-1:0] PRE_L = PC_W'(PREAMBLE_LEN);
  logic [PC_W-1:0] preamble_cnt_q, preamble_cnt_d;

  always_comb begin
    preamble_cnt_d = preamble_cnt_q;
    if (!preamble_counter_mode)                   preamble_cnt_d = '0;
    else if (sample_valid && preamble_cnt_q < PRE_L) preamble_cnt_d = preamble_cnt_q + 1'b1;
  end

  // In-band settling takes priority over a budget expiry in the same cycle.
  assign to_hit = ~done_q & (preamble_cnt_d == PRE_L) & ~inband;

  always_ff @(posedge clk) begin
    if (RESET) preamble_cnt_q <= '0;
    else       preamble_cnt_q <= preamble_cnt_d;
  end
`else
  logic unused_pcm;
  assign unused_pcm = preamble_counter_mode;
  assign to_hit     = 1'b0;
`endif

  assign done_set  = inband | to_hit;
  assign done_d    = done_q | done_set;
  assign timeout_d = timeout_q | to_hit;

  // One step per adjust rising edge; frozen once settled or settling this cycle.
  always_comb begin
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    if (adj_rise && !done_q && !done_set) begin
      if (up_dn && gain_q != GAIN_MAX) begin
        gain_d        = gain_q + 1'b1;
        gain_update_d = 1'b1;
      end else if (!up_dn && gain_q != '0) begin
        gain_d        = gain_q - 1'b1;
        gain_update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      detect_d_q    <= 1'b0;
      adjust_d_q    <= 1'b0;
      peak_q        <= '0;
      win_cnt_q     <= '0;
      indicator_q   <= 1'b0;
      done_q        <= 1'b0;
      gain_q        <= GAIN_RST;
      gain_update_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      detect_d_q    <= detect_mode;
      adjust_d_q    <= adjust;
      peak_q        <= peak_d;
      win_cnt_q     <= win_cnt_d;
      indicator_q   <= indicator_d;
      done_q        <= done_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      timeout_q     <= timeout_d;
    end
  end

  assign indicator   = indicator_q;
  assign done        = done_q;
  assign gain        = gain_q;
  assign gain_update = gain_update_q;
  assign timeout     = timeout_q;

endmodule
